game_state_controller: RTL and testbench

//  Round/level sequencer for the frogger top. Consumes the collision flags and player start input.

---
 rtl/game_state_controller_pkg.sv | 28 ++
 rtl/game_state_controller_if.sv | 27 ++
 rtl/game_state_controller_tick_timer.sv | 50 +++++
 rtl/game_state_controller.sv | 130 +++++++++++++
 tb/tb_game_state_controller.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/game_state_controller_pkg.sv
// Shared state codes, field widths and the round context record for the frogger game sequencer.
// Display decoders and the controller agree on these numeric state codes.
package game_state_controller_pkg;

    localparam int STATE_W = 3;
    localparam int LEVEL_W = 4;
    localparam int LIVES_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_PLAY      = 3'd1;
    localparam logic [STATE_W-1:0] ST_DYING     = 3'd2;
    localparam logic [STATE_W-1:0] ST_LEVEL_UP  = 3'd3;
    localparam logic [STATE_W-1:0] ST_GAME_OVER = 3'd4;
    localparam logic [STATE_W-1:0] ST_VICTORY   = 3'd5;

    typedef struct packed {
        logic [STATE_W-1:0] state;
        logic [LEVEL_W-1:0] level;
        logic [LIVES_W-1:0] lives;
    } round_ctx_t;

    // States that run the shared hold/flash timer.
    function automatic logic is_timed_state(input logic [STATE_W-1:0] s);
        return (s == ST_DYING) || (s == ST_LEVEL_UP) ||
               (s == ST_GAME_OVER) || (s == ST_VICTORY);
    endfunction

endpackage

// File: rtl/game_state_controller_if.sv
// Game sequencer bundle: collision/start/tick inputs and level/lives/round control outputs.
// Names are from the controller's view; master drives the i_ side, slave is the controller.
interface game_state_controller_if;
    import game_state_controller_pkg::*;

    logic               i_tick;
    logic               i_start;
    logic               i_death_collision;
    logic               i_win_collision;
    logic [LEVEL_W-1:0] o_current_level;
    logic [LIVES_W-1:0] o_lives;
    logic               o_round_reset;
    logic               o_freeze;
    logic               o_flash;
    logic [STATE_W-1:0] o_game_state;

    modport master (
        output i_tick, i_start, i_death_collision, i_win_collision,
        input  o_current_level, o_lives, o_round_reset, o_freeze, o_flash, o_game_state
    );

    modport slave (
        input  i_tick, i_start, i_death_collision, i_win_collision,
        output o_current_level, o_lives, o_round_reset, o_freeze, o_flash, o_game_state
    );

endinterface

// File: rtl/game_state_controller_tick_timer.sv
// Tick-counting hold timer with a saturating terminal count and a flash toggle (starts high on clear).
// Outputs are registered; stop forces idle (flash low), clear restarts, ticks advance otherwise.
module game_state_controller_tick_timer
    import game_state_controller_pkg::*;
#(
    parameter int HOLD_TICKS  = 50,
    parameter int FLASH_TICKS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_stop,
    input  logic i_tick,
    output logic o_done,
    output logic o_flash
);

    localparam int CNT_W = $clog2(HOLD_TICKS + 1);
    localparam int PH_W  = $clog2(FLASH_TICKS + 1);

    logic [CNT_W-1:0] r_count;
    logic [PH_W-1:0]  r_phase;
    logic             r_flash;

    always_ff @(posedge clk) begin
        if (reset || i_stop) begin
            r_count <= '0;
            r_phase <= '0;
            r_flash <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_phase <= '0;
            r_flash <= 1'b1;
        end else if (i_tick) begin
            if (r_count != CNT_W'(HOLD_TICKS))
                r_count <= r_count + 1'b1;
            // Flash keeps running after the hold count saturates (end-of-game screens).
            if (r_phase == PH_W'(FLASH_TICKS - 1)) begin
                r_phase <= '0;
                r_flash <= ~r_flash;
            end else begin
                r_phase <= r_phase + 1'b1;
            end
        end
    end

    assign o_done  = (r_count == CNT_W'(HOLD_TICKS));
    assign o_flash = r_flash;

endmodule

// File: rtl/game_state_controller.sv
// Frogger round/level sequencer: tracks level and lives, issues a one-cycle round_reset and freeze/flash.
// All outputs registered; start sees 2 sync flops plus edge detect; no backpressure, inputs are levels.
module game_state_controller #(
    parameter int NUM_LIVES   = 3,
    parameter int MAX_LEVEL   = 8,
    parameter int HOLD_TICKS  = 50,
    parameter int FLASH_TICKS = 10,
    parameter int GRACE_CYC   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    game_state_controller_if.slave bus
);
    import game_state_controller_pkg::*;

    localparam int GRACE_W = $clog2(GRACE_CYC + 2);

    round_ctx_t         r_ctx;
    round_ctx_t         w_nxt;
    logic               r_start_s1;
    logic               r_start_s2;
    logic               r_start_d;
    logic               w_start_rise;
    logic [GRACE_W-1:0] r_grace;
    logic               r_round_reset;
    logic               r_freeze;
    logic               w_go_play;
    logic               w_clear;
    logic               w_stop;
    logic               w_done;
    logic               w_flash;

    assign w_start_rise = r_start_s2 & ~r_start_d;

    always_comb begin
        w_nxt     = r_ctx;
        w_go_play = 1'b0;
        case (r_ctx.state)
            ST_IDLE: begin
                if (w_start_rise) begin
                    w_nxt.state = ST_PLAY;
                    w_go_play   = 1'b1;
                end
            end
            ST_PLAY: begin
                // Death outranks a simultaneous win; both are masked while grace runs.
                if (r_grace == '0) begin
                    if (bus.i_death_collision) begin
                        if (r_ctx.lives > LIVES_W'(1)) begin
                            w_nxt.lives = r_ctx.lives - 1'b1;
                            w_nxt.state = ST_DYING;
                        end else begin
                            w_nxt.lives = '0;
                            w_nxt.state = ST_GAME_OVER;
                        end
                    end else if (bus.i_win_collision) begin
                        w_nxt.state = (r_ctx.level < LEVEL_W'(MAX_LEVEL)) ? ST_LEVEL_UP : ST_VICTORY;
                    end
                end
            end
            ST_DYING, ST_LEVEL_UP: begin
                if (w_done) begin
                    w_nxt.state = ST_PLAY;
                    w_go_play   = 1'b1;
                    if ((r_ctx.state == ST_LEVEL_UP) && (r_ctx.level < LEVEL_W'(MAX_LEVEL)))
                        w_nxt.level = r_ctx.level + 1'b1;
                end
            end
            ST_GAME_OVER, ST_VICTORY: begin
                if (w_start_rise) begin
                    w_nxt.state = ST_PLAY;
                    w_nxt.level = LEVEL_W'(1);
                    w_nxt.lives = LIVES_W'(NUM_LIVES);
                    w_go_play   = 1'b1;
                end
            end
            default: begin
                w_nxt.state = ST_IDLE;
            end
        endcase
    end

    // Timer restarts on entry to any timed state and idles whenever the next state is untimed.
    assign w_clear = is_timed_state(w_nxt.state) && (w_nxt.state != r_ctx.state);
    assign w_stop  = !is_timed_state(w_nxt.state);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctx         <= '{state: ST_IDLE, level: LEVEL_W'(1), lives: LIVES_W'(NUM_LIVES)};
            r_start_s1    <= 1'b0;
            r_start_s2    <= 1'b0;
            r_start_d     <= 1'b0;
            r_grace       <= '0;
            r_round_reset <= 1'b0;
            r_freeze      <= 1'b1;
        end else begin
            r_start_s1    <= bus.i_start;
            r_start_s2    <= r_start_s1;
            r_start_d     <= r_start_s2;
            r_ctx         <= w_nxt;
            r_round_reset <= w_go_play;
            r_freeze      <= (w_nxt.state != ST_PLAY);
            if (w_go_play)
                r_grace <= GRACE_W'(GRACE_CYC);
            else if ((r_ctx.state == ST_PLAY) && (r_grace != '0))
                r_grace <= r_grace - 1'b1;
        end
    end

    game_state_controller_tick_timer #(
        .HOLD_TICKS  (HOLD_TICKS),
        .FLASH_TICKS (FLASH_TICKS)
    ) u_tick_timer (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .i_stop  (w_stop),
        .i_tick  (bus.i_tick),
        .o_done  (w_done),
        .o_flash (w_flash)
    );

    assign bus.o_game_state    = r_ctx.state;
    assign bus.o_current_level = r_ctx.level;
    assign bus.o_lives         = r_ctx.lives;
    assign bus.o_round_reset   = r_round_reset;
    assign bus.o_freeze        = r_freeze;
    assign bus.o_flash         = w_flash;

endmodule

// File: tb/tb_game_state_controller.sv
// Bench for game_state_controller: directed scenarios then random play, all checked against a round model.
module tb_game_state_controller;

    localparam int NL = 3;
    localparam int ML = 8;
    localparam int HT = 4;
    localparam int FT = 2;
    localparam int GC = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    game_state_controller_if bus();

    game_state_controller #(
        .NUM_LIVES(NL), .MAX_LEVEL(ML), .HOLD_TICKS(HT), .FLASH_TICKS(FT), .GRACE_CYC(GC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: game rules in plain integers (state code, level, lives, ticks since entry).
    int m_state, m_level, m_lives, m_ticks, m_age, tcnt;
    bit m_rr, sh0, sh1, sh2;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_flash();
        if (m_state >= 2 && m_state <= 5)
            return ((m_ticks / FT) % 2 == 0) ? 1 : 0;
        return 0;
    endfunction

    task automatic enter_play();
        m_state = 1; m_rr = 1'b1; m_age = 0; m_ticks = 0;
    endtask

    task automatic enter_hold(input int s);
        m_state = s; m_ticks = 0;
    endtask

    task automatic model_step();
        bit rise;
        if (reset) begin
            m_state = 0; m_level = 1; m_lives = NL; m_ticks = 0; m_age = 0;
            m_rr = 1'b0; sh0 = 1'b0; sh1 = 1'b0; sh2 = 1'b0;
        end else begin
            rise = sh1 && !sh2;
            sh2 = sh1; sh1 = sh0; sh0 = bus.i_start;
            m_rr = 1'b0;
            case (m_state)
                0: if (rise) enter_play();
                1: begin
                    if (m_age < GC) m_age++;
                    else if (bus.i_death_collision) begin
                        if (m_lives > 1) begin m_lives--; enter_hold(2); end
                        else begin m_lives = 0; enter_hold(4); end
                    end else if (bus.i_win_collision)
                        enter_hold(m_level < ML ? 3 : 5);
                end
                2, 3: begin
                    if (m_ticks >= HT) begin
                        if (m_state == 3 && m_level < ML) m_level++;
                        enter_play();
                    end else if (bus.i_tick) m_ticks++;
                end
                default: begin
                    if (rise) begin m_level = 1; m_lives = NL; enter_play(); end
                    else if (bus.i_tick) m_ticks++;
                end
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_state", bus.o_game_state, m_state);
        check("model_level", bus.o_current_level, m_level);
        check("model_lives", bus.o_lives, m_lives);
        check("model_round_reset", bus.o_round_reset, m_rr);
        check("model_freeze", bus.o_freeze, (m_state != 1) ? 1 : 0);
        check("model_flash", bus.o_flash, exp_flash());
        bus.i_tick = (tcnt % 4 == 3);
        tcnt++;
    endtask

    task automatic wait_state(input int s, input int bound, input string tag);
        for (int k = 0; k < bound && bus.o_game_state != s; k++) cycle();
        check(tag, bus.o_game_state, s);
    endtask

    task automatic wait_rr(input int bound, input string tag);
        for (int k = 0; k < bound && !bus.o_round_reset; k++) cycle();
        check(tag, bus.o_round_reset, 1);
    endtask

    task automatic level_up(input string tag);
        bus.i_win_collision = 1'b1;
        wait_state(3, 10, tag);
        bus.i_win_collision = 1'b0;
        wait_rr(60, {tag, "_rr"});
    endtask

    task automatic lose_life(input string tag);
        bus.i_death_collision = 1'b1;
        wait_state(2, 10, tag);
        bus.i_death_collision = 1'b0;
        wait_rr(60, {tag, "_rr"});
    endtask

    initial begin
        bus.i_tick = 1'b0; bus.i_start = 1'b0;
        bus.i_death_collision = 1'b0; bus.i_win_collision = 1'b0;
        tcnt = 0;
        reset = 1'b1;
        cycle(); cycle();
        check("rst_state", bus.o_game_state, 0);
        check("rst_level", bus.o_current_level, 1);
        check("rst_lives", bus.o_lives, 3);
        check("rst_freeze", bus.o_freeze, 1);
        check("rst_flash", bus.o_flash, 0);
        check("rst_round_reset", bus.o_round_reset, 0);
        reset = 1'b0;

        // Start from IDLE
        cycle();
        bus.i_start = 1'b1;
        wait_rr(10, "s1_rr");
        check("s1_state", bus.o_game_state, 1);
        check("s1_freeze", bus.o_freeze, 0);
        check("s1_level", bus.o_current_level, 1);
        check("s1_lives", bus.o_lives, 3);
        cycle();
        check("s1_rr_one_cycle", bus.o_round_reset, 0);

        // Death at 3 lives, flash pattern, grace on re-entry with death held
        bus.i_death_collision = 1'b1;
        wait_state(2, 10, "s2_dying");
        check("s2_lives", bus.o_lives, 2);
        check("s2_freeze", bus.o_freeze, 1);
        check("s6_flash_start", bus.o_flash, 1);
        for (int k = 0; k < 40 && m_ticks < 2; k++) cycle();
        check("s6_flash_low", bus.o_flash, 0);
        wait_rr(60, "s2_rr");
        check("s2_back_play", bus.o_game_state, 1);
        check("s6_flash_play", bus.o_flash, 0);
        cycle(); cycle();
        bus.i_death_collision = 1'b0;
        check("s2_grace_lives", bus.o_lives, 2);
        cycle();
        check("s2_grace_state", bus.o_game_state, 1);

        // Level ups to 8, then victory
        level_up("s3_l2");
        level_up("s3_l3");
        check("s3_level3", bus.o_current_level, 3);
        bus.i_win_collision = 1'b1;
        wait_state(3, 10, "s3_levelup");
        bus.i_win_collision = 1'b0;
        check("s3_level_hold", bus.o_current_level, 3);
        wait_rr(60, "s3_rr");
        check("s3_level4", bus.o_current_level, 4);
        for (int k = 0; k < 4; k++) level_up("s3_climb");
        check("s3_level8", bus.o_current_level, 8);
        bus.i_win_collision = 1'b1;
        wait_state(5, 10, "s3_victory");
        bus.i_win_collision = 1'b0;
        check("s3_victory_level", bus.o_current_level, 8);
        repeat (30) cycle();
        check("s3_victory_stays", bus.o_game_state, 5);

        // Restart from VICTORY, reach 1 life, then simultaneous death+win
        bus.i_start = 1'b0;
        repeat (4) cycle();
        bus.i_start = 1'b1;
        wait_rr(10, "s4_restart_rr");
        check("s4_restart_lives", bus.o_lives, 3);
        lose_life("s4_die1");
        lose_life("s4_die2");
        level_up("s4_lvl2");
        bus.i_death_collision = 1'b1;
        bus.i_win_collision = 1'b1;
        wait_state(4, 10, "s4_game_over");
        bus.i_death_collision = 1'b0;
        bus.i_win_collision = 1'b0;
        check("s4_lives0", bus.o_lives, 0);
        check("s4_level_kept", bus.o_current_level, 2);
        repeat (12) cycle();
        check("s4_held_start", bus.o_game_state, 4);
        bus.i_start = 1'b0;
        repeat (4) cycle();
        bus.i_start = 1'b1;
        wait_rr(10, "s4_restart2_rr");
        check("s4_restart2_level", bus.o_current_level, 1);
        check("s4_restart2_lives", bus.o_lives, 3);
        check("s4_restart2_state", bus.o_game_state, 1);

        // Reset during the DYING hold
        bus.i_start = 1'b0;
        bus.i_death_collision = 1'b1;
        wait_state(2, 10, "s5_dying");
        bus.i_death_collision = 1'b0;
        for (int k = 0; k < 40 && m_ticks < 2; k++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("s5_state", bus.o_game_state, 0);
        check("s5_rr", bus.o_round_reset, 0);
        check("s5_lives", bus.o_lives, 3);
        check("s5_freeze", bus.o_freeze, 1);
        check("s5_flash", bus.o_flash, 0);
        repeat (40) cycle();
        check("s5_stays_idle", bus.o_game_state, 0);

        // Random play against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) bus.i_start = ~bus.i_start;
            bus.i_death_collision = ($urandom_range(0, 15) == 0);
            bus.i_win_collision = ($urandom_range(0, 11) == 0);
            reset = ($urandom_range(0, 599) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
